// File: rtl/mem_arb_pkg.sv
// Shared constants, request record and word-address helper for mem_port_arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_NUM_REQ   = 4;
    localparam int unsigned DEF_ADDR_BITS = 24;
    localparam int unsigned DEF_DATA_BITS = 32;
    localparam int unsigned WA_MAX_BITS   = 64;

    typedef struct packed {
        logic                     wren;
        logic [DEF_ADDR_BITS-1:0] addr;
        logic [DEF_DATA_BITS-1:0] wdata;
    } req_t;

    // Byte address to word address; callers zero-extend to WA_MAX_BITS.
    function automatic logic [WA_MAX_BITS-1:0] word_addr(input logic [WA_MAX_BITS-1:0] addr);
        return addr >> 2;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick: circular find-first-set over i_mask starting at i_start.
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     i_mask,
    input  logic [IDX_W-1:0] i_start,
    output logic             o_found,
    output logic [IDX_W-1:0] o_index
);

    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!o_found && i_mask[IDX_W'((32'(i_start) + k) % N)]) begin
                o_found = 1'b1;
                o_index = IDX_W'((32'(i_start) + k) % N);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing a dual-port word memory between NUM_REQ requesters.
// Optional MEM_ARB_STATS_EN adds saturating grant / conflict counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
    parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_wren,
    input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [NUM_REQ*DATA_BITS-1:0]   rsp_rdata,
    output logic [ADDR_BITS-1:0]           mem_address_0,
    output logic [ADDR_BITS-1:0]           mem_address_1,
    output logic [DATA_BITS-1:0]           mem_data_0,
    output logic [DATA_BITS-1:0]           mem_data_1,
    output logic                           mem_wren_0,
    output logic                           mem_wren_1,
    input  logic [DATA_BITS-1:0]           mem_q_0,
    input  logic [DATA_BITS-1:0]           mem_q_1
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]          stat_grant_cnt,
    output logic [15:0]                    stat_conflict_cnt
`endif
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    logic [ADDR_BITS-1:0]         w_addr  [NUM_REQ];
    logic [DATA_BITS-1:0]         w_wdata [NUM_REQ];
    logic [PTR_W-1:0]             r_rr_ptr;
    logic [NUM_REQ-1:0]           r_rsp_valid;
    logic [NUM_REQ*DATA_BITS-1:0] r_rsp_rdata;
    logic                         w_found_a, w_found_b;
    logic [PTR_W-1:0]             w_idx_a, w_idx_b, w_start_b;
    logic [NUM_REQ-1:0]           w_mask_b;
    logic                         w_conflict, w_grant_a, w_grant_b;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr[g]  = req_addr[g*ADDR_BITS +: ADDR_BITS];
        assign w_wdata[g] = req_wdata[g*DATA_BITS +: DATA_BITS];
    end

    rr_pick #(.N(NUM_REQ), .IDX_W(PTR_W)) u_pick_a (
        .i_mask  (req_valid),
        .i_start (r_rr_ptr),
        .o_found (w_found_a),
        .o_index (w_idx_a)
    );

    assign w_mask_b  = req_valid & ~(NUM_REQ'(1) << w_idx_a);
    assign w_start_b = next_idx(w_idx_a);

    rr_pick #(.N(NUM_REQ), .IDX_W(PTR_W)) u_pick_b (
        .i_mask  (w_mask_b),
        .i_start (w_start_b),
        .o_found (w_found_b),
        .o_index (w_idx_b)
    );

    // Same word with any write on either side: port 1 backs off, request stays pending.
    assign w_conflict = w_found_b
                     && (word_addr(WA_MAX_BITS'(w_addr[w_idx_a])) == word_addr(WA_MAX_BITS'(w_addr[w_idx_b])))
                     && (req_wren[w_idx_a] || req_wren[w_idx_b]);

    assign w_grant_a = reset_n && w_found_a;
    assign w_grant_b = reset_n && w_found_b && !w_conflict;

    always_comb begin
        req_ready = '0;
        if (w_grant_a) req_ready[w_idx_a] = 1'b1;
        if (w_grant_b) req_ready[w_idx_b] = 1'b1;
    end

    always_comb begin
        mem_address_0 = '0;
        mem_data_0    = '0;
        mem_wren_0    = 1'b0;
        mem_address_1 = '0;
        mem_data_1    = '0;
        mem_wren_1    = 1'b0;
        if (w_grant_a) begin
            mem_address_0 = w_addr[w_idx_a];
            mem_data_0    = w_wdata[w_idx_a];
            mem_wren_0    = req_wren[w_idx_a];
        end
        if (w_grant_b) begin
            mem_address_1 = w_addr[w_idx_b];
            mem_data_1    = w_wdata[w_idx_b];
            mem_wren_1    = req_wren[w_idx_b];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_rr_ptr    <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= req_ready;
            if (w_grant_a && !req_wren[w_idx_a])
                r_rsp_rdata[w_idx_a*DATA_BITS +: DATA_BITS] <= mem_q_0;
            if (w_grant_b && !req_wren[w_idx_b])
                r_rsp_rdata[w_idx_b*DATA_BITS +: DATA_BITS] <= mem_q_1;
            if (w_grant_b)
                r_rr_ptr <= next_idx(w_idx_b);
            else if (w_grant_a)
                r_rr_ptr <= next_idx(w_idx_a);
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] r_grant_cnt [NUM_REQ];
    logic [15:0] r_conflict_cnt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) r_grant_cnt[i] <= '0;
            r_conflict_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++)
                if (req_ready[i] && (r_grant_cnt[i] != '1)) r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
            if (w_conflict && (r_conflict_cnt != '1)) r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign stat_grant_cnt[g*16 +: 16] = r_grant_cnt[g];
    end
    assign stat_conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a queue-based arbitration model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int NR = 4;
    localparam int AW = 24;
    localparam int DW = 32;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [NR-1:0]    req_valid, req_ready, req_wren, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata, rsp_rdata;
    logic [AW-1:0]    mem_address_0, mem_address_1;
    logic [DW-1:0]    mem_data_0, mem_data_1, mem_q_0, mem_q_1;
    logic             mem_wren_0, mem_wren_1;
`ifdef MEM_ARB_STATS_EN
    logic [NR*16-1:0] stat_grant_cnt;
    logic [15:0]      stat_conflict_cnt;
`endif

    always #5 clock = ~clock;

    mem_port_arbiter #(.NUM_REQ(NR), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wren(req_wren),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_address_0(mem_address_0), .mem_address_1(mem_address_1),
        .mem_data_0(mem_data_0), .mem_data_1(mem_data_1),
        .mem_wren_0(mem_wren_0), .mem_wren_1(mem_wren_1),
        .mem_q_0(mem_q_0), .mem_q_1(mem_q_1)
`ifdef MEM_ARB_STATS_EN
        , .stat_grant_cnt(stat_grant_cnt), .stat_conflict_cnt(stat_conflict_cnt)
`endif
    );

    // Memory environment (256 words, byte addresses below 1024)
    logic [DW-1:0] tb_mem [256];
    logic          pl_en = 1'b0;
    logic [7:0]    pl_addr;
    logic [DW-1:0] pl_data;

    always @(posedge clock) begin
        if (pl_en) tb_mem[pl_addr] <= pl_data;
        else begin
            if (mem_wren_0) tb_mem[mem_address_0[9:2]] <= mem_data_0;
            if (mem_wren_1) tb_mem[mem_address_1[9:2]] <= mem_data_1;
        end
    end
    assign mem_q_0 = tb_mem[mem_address_0[9:2]];
    assign mem_q_1 = tb_mem[mem_address_1[9:2]];

    // Reference model state
    logic [DW-1:0] ref_mem [256];
    int            ptr;
    logic [NR-1:0] exp_v;
    logic [DW-1:0] exp_rd [NR];
    logic          pv [NR];
    req_t          p  [NR];
    logic [NR-1:0] obs_ready;
    int            rsp_cnt [NR];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset_state();
        ptr   = 0;
        exp_v = '0;
        for (int i = 0; i < NR; i++) exp_rd[i] = '0;
    endtask

    task automatic step();
        int            order[$];
        int            a, b;
        bit            ga, gb;
        logic [NR-1:0] er;
        @(negedge clock);
        for (int i = 0; i < NR; i++) begin
            req_valid[i]           = pv[i];
            req_wren[i]            = p[i].wren;
            req_addr[i*AW +: AW]   = p[i].addr;
            req_wdata[i*DW +: DW]  = p[i].wdata;
        end
        #1;
        er = '0; ga = 0; gb = 0; a = 0; b = 0;
        if (reset_n) begin
            for (int k = 0; k < NR; k++) begin
                int i = (ptr + k) % NR;
                if (pv[i]) order.push_back(i);
            end
            if (order.size() > 0) begin ga = 1; a = order[0]; end
            if (order.size() > 1) begin
                b  = order[1];
                gb = !(((p[a].addr >> 2) == (p[b].addr >> 2)) && (p[a].wren || p[b].wren));
            end
            if (ga) er[a] = 1'b1;
            if (gb) er[b] = 1'b1;
        end
        check("req_ready", req_ready, er);
        check("wren0", mem_wren_0, ga && p[a].wren);
        check("addr0", mem_address_0, ga ? p[a].addr : '0);
        check("data0", mem_data_0, ga ? p[a].wdata : '0);
        check("wren1", mem_wren_1, gb && p[b].wren);
        check("addr1", mem_address_1, gb ? p[b].addr : '0);
        check("data1", mem_data_1, gb ? p[b].wdata : '0);
        obs_ready = req_ready;
        if (!reset_n) model_reset_state();
        else begin
            exp_v = er;
            if (ga && !p[a].wren) exp_rd[a] = ref_mem[p[a].addr[9:2]];
            if (gb && !p[b].wren) exp_rd[b] = ref_mem[p[b].addr[9:2]];
            if (ga && p[a].wren) ref_mem[p[a].addr[9:2]] = p[a].wdata;
            if (gb && p[b].wren) ref_mem[p[b].addr[9:2]] = p[b].wdata;
            if (gb) ptr = (b + 1) % NR;
            else if (ga) ptr = (a + 1) % NR;
        end
        @(posedge clock);
        #1;
        check("rsp_valid", rsp_valid, exp_v);
        for (int i = 0; i < NR; i++) begin
            check($sformatf("rdata%0d", i), rsp_rdata[i*DW +: DW], exp_rd[i]);
            if (rsp_valid[i]) rsp_cnt[i]++;
            if (er[i]) pv[i] = 1'b0;
        end
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        pv[i]      = 1'b1;
        p[i].wren  = wr;
        p[i].addr  = ad;
        p[i].wdata = wd;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NR; i++) begin
            pv[i] = 1'b0;
            p[i]  = '0;
        end
    endtask

    task automatic do_reset();
        clear_reqs();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_wren  = '0;
        req_addr  = '0;
        req_wdata = '0;
        model_reset_state();
        clear_reqs();

        // Preload environment and reference memory with identical contents
        for (int w = 0; w < 256; w++) begin
            logic [DW-1:0] v;
            v = (w == 4) ? 32'hAAAA_0004 : (w == 8) ? 32'hBBBB_0008 : $urandom;
            ref_mem[w] = v;
            @(negedge clock);
            pl_en = 1'b1; pl_addr = 8'(w); pl_data = v;
        end
        @(negedge clock);
        pl_en = 1'b0;

        // Reset with every requester asking
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 24'(i * 4), 32'hFFFF_0000);
        step();
        step();
        check("rst_ready", obs_ready, 4'b0000);
        reset_n = 1'b1;
        clear_reqs();

        // Dual read
        set_req(0, 1'b0, 24'h10, '0);
        set_req(1, 1'b0, 24'h20, '0);
        step();
        check("dual_ready", obs_ready, 4'b0011);
        check("dual_rsp", rsp_valid, 4'b0011);
        check("dual_rd0", rsp_rdata[31:0], 32'hAAAA_0004);
        check("dual_rd1", rsp_rdata[63:32], 32'hBBBB_0008);
        set_req(0, 1'b0, 24'h100, '0);
        set_req(1, 1'b0, 24'h104, '0);
        set_req(2, 1'b0, 24'h108, '0);
        step();
        check("ptr_after_dual", obs_ready, 4'b0101);
        step();
        check("ptr_leftover", obs_ready, 4'b0010);

        // Write/write conflict
        do_reset();
        set_req(0, 1'b1, 24'h40, 32'hDEAD_BEEF);
        set_req(2, 1'b1, 24'h40, 32'h1234_5678);
        step();
        check("wc_cyc1", obs_ready, 4'b0001);
        step();
        check("wc_cyc2", obs_ready, 4'b0100);
        set_req(1, 1'b0, 24'h40, '0);
        step();
        check("wc_read", rsp_rdata[63:32], 32'h1234_5678);

        // Read after write to the same word
        do_reset();
        set_req(1, 1'b1, 24'h44, 32'hCAFE_F00D);
        set_req(3, 1'b0, 24'h46, '0);
        step();
        check("rw_cyc1", obs_ready, 4'b0010);
        step();
        check("rw_cyc2", obs_ready, 4'b1000);
        check("rw_data", rsp_rdata[127:96], 32'hCAFE_F00D);

        // Fairness: all valid, distinct words
        do_reset();
        for (int i = 0; i < NR; i++) rsp_cnt[i] = 0;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NR; i++)
                if (!pv[i]) set_req(i, 1'b0, 24'(12'h200 + i * 4 + c * 16), '0);
            step();
            check("fair_grant", obs_ready, (c % 2 == 0) ? 4'b0011 : 4'b1100);
        end
        for (int i = 0; i < NR; i++) check($sformatf("fair_cnt%0d", i), 64'(rsp_cnt[i]), 64'd4);

        // Randomized traffic with occasional reset
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NR; i++)
                if (!pv[i] && ($urandom_range(0, 3) != 0))
                    set_req(i, 1'($urandom_range(0, 1)),
                            24'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)), $urandom);
            reset_n = ($urandom_range(0, 99) != 0);
            step();
            reset_n = 1'b1;
        end

`ifdef MEM_ARB_STATS_EN
        // Saturation of the conflict counter under permanent same-word writes
        do_reset();
        check("stat_conf_rst", stat_conflict_cnt, 16'h0000);
        @(negedge clock);
        req_valid = 4'b0011;
        req_wren  = 4'b0011;
        req_addr  = {24'h0, 24'h0, 24'h80, 24'h80};
        for (int c = 0; c < 70000; c++) @(posedge clock);
        #1;
        check("stat_conf_sat", stat_conflict_cnt, 16'hFFFF);
        check("stat_grant_sum", 64'(stat_grant_cnt[15:0]) + 64'(stat_grant_cnt[31:16]), 64'd70000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the two ports of the team's dual-port word memory between NUM_REQ requesters, e.g. instruction fetch, data load/store, debug and DMA.
- Grants up to two requests per cycle using round-robin priority.
- Drives the memory's address, data and write-enable pins, and returns registered read data or a write acknowledge.
- Sits between the core/bus masters and the memory instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_BITS, 24, byte-address width, matching the memory's address port.
- DATA_BITS, 32, data word width.

Ports:
- clock, input, 1, system clock; all logic is on the rising edge.
- reset_n, input, 1, synchronous active-low reset.
- req_valid, input, NUM_REQ, request pending per requester.
- req_ready, output, NUM_REQ, grant per requester; a transfer occurs when valid and ready are both high.
- req_wren, input, NUM_REQ, 1 = write, 0 = read.
- req_addr, input, NUM_REQ*ADDR_BITS, byte address per requester; slice i belongs to requester i.
- req_wdata, input, NUM_REQ*DATA_BITS, write data per requester.
- rsp_valid, output, NUM_REQ, one-cycle pulse completing a granted request.
- rsp_rdata, output, NUM_REQ*DATA_BITS, read data, valid while rsp_valid[i] is high.
- mem_address_0, mem_address_1, output, ADDR_BITS each, memory port addresses.
- mem_data_0, mem_data_1, output, DATA_BITS each, memory write data.
- mem_wren_0, mem_wren_1, output, 1 each, memory write enables.
- mem_q_0, mem_q_1, input, DATA_BITS each, memory read data (combinational read).

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
- Reset values:
  - rr_ptr = 0.
  - rsp_valid = 0.
  - rsp_rdata = 0.
  - req_ready is combinational and is 0 while reset_n = 0.
- Pick A (port 0): first valid requester searching from rr_ptr upward, with wrap-around.
- Pick B (port 1): next valid requester after A in the same circular order, excluding A.
- Conflict rule: B is suppressed if the word addresses match (addr[ADDR_BITS-1:2]) and either A or B is a write. This prevents double-writes and read/write ambiguity on the same word. B then stays pending.
- req_ready is combinational: 1 only for the granted A and the granted, unsuppressed B. A requester's fields must stay stable while valid is high and ready is low.
- Memory drive:
  - A granted port gets its requester's address, wdata and wren.
  - An idle port drives address 0, data 0, wren 0.
  - Writes commit at the granting edge.
- Response:
  - At the edge after a grant, rsp_valid[i] = 1 for one cycle.
  - rsp_rdata slice i = the mem_q captured at the granting edge for reads.
  - For writes, rsp_rdata slice i is unchanged.
  - Non-granted slices hold their previous rdata.
- Pipelining: a requester may be granted again in the cycle its rsp_valid is high. This gives one request per cycle per requester and single-cycle latency.
- Pointer update: rr_ptr = (index of the last grant issued this cycle) + 1, modulo NUM_REQ. rr_ptr is unchanged when nothing is granted.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles, even under constant conflicts.
- Boundary cases:
  - Only one requester valid: port 1 stays idle.
  - No requester valid: both ports idle, no rsp_valid.
  - Reset asserted while a grant is pending: the write already committed stays committed, the response is dropped, and rsp_valid = 0 on the next cycle.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, adds two outputs:
  - stat_grant_cnt, NUM_REQ*16 bits, per-requester grant counters.
  - stat_conflict_cnt, 16 bits, counts cycles in which B was suppressed.
- Counters saturate at 16'hFFFF, clear on reset, and are otherwise free-running.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - the default parameter constants;
  - typedef req_t {wren, addr, wdata};
  - the function word_addr() for the conflict compare.
- Sub-module rr_pick: circular find-first from a start index with a mask; returns found and index. It is instantiated twice, once for A and once for B, with A masked out for B.

Test Plan:
- Reset: reset_n = 0 for 2 cycles with all req_valid = 1 -> req_ready = 0, rsp_valid = 0, mem_wren_0 = mem_wren_1 = 0.
- Dual read: req 0 reads 0x10 and req 1 reads 0x20, memory preloaded with 0xAAAA_0004 and 0xBBBB_0008 -> both granted in the same cycle; next cycle rsp_valid = 4'b0011 with matching rdata; rr_ptr = 2.
- Write conflict: req 0 writes 0xDEAD_BEEF and req 2 writes 0x1234_5678, both to 0x40, rr_ptr = 0 -> cycle 1 grants only req 0; cycle 2 grants req 2; a final read of 0x40 returns 0x1234_5678.
- Read/write same word: req 1 writes 0x44 while req 3 reads 0x44 -> req 3 is deferred one cycle and reads the new data.
- Fairness: all 4 requesters valid for 8 cycles with distinct addresses -> grants (0,1), (2,3), (0,1), ...; each requester gets 4 responses.
- Stats with MEM_ARB_STATS_EN defined: 70000 forced conflicts -> stat_conflict_cnt saturates at 0xFFFF.
